// File: rtl/canyon_pkg.sv
// Canyon Bomber ROM download sequencer shared types.
// FSM encoding and default ROM map geometry.
package canyon_pkg;

  typedef enum logic [2:0] {
    HOLD,
    RUN,
    LOAD,
    CHECK,
    FAULT
  } dl_state_t;

  localparam int DEF_REGION_AW      = 11;
  localparam int DEF_NUM_REGIONS    = 4;
  localparam int DEF_EXPECTED_BYTES = DEF_NUM_REGIONS << DEF_REGION_AW;
  localparam int DEF_HOLD_CYCLES    = 16;

  localparam int BYTE_CNT_W = 14;
  localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = '1;

  localparam logic [1:0] RGN_0 = 2'd0;
  localparam logic [1:0] RGN_1 = 2'd1;
  localparam logic [1:0] RGN_2 = 2'd2;
  localparam logic [1:0] RGN_3 = 2'd3;

endpackage

// File: rtl/rom_download_sequencer.sv
// Canyon Bomber ROM download sequencer.
// Routes ioctl bytes to ROM regions and owns the core reset.
module rom_download_sequencer
  import canyon_pkg::*;
#(
  parameter int REGION_AW      = DEF_REGION_AW,
  parameter int NUM_REGIONS    = DEF_NUM_REGIONS,
  parameter int EXPECTED_BYTES = DEF_EXPECTED_BYTES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES
) (
  input  logic                   clk_sys,
  input  logic                   Reset_I,
  input  logic                   ext_reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_data,
  output logic [NUM_REGIONS-1:0] rom_wr,
  output logic [REGION_AW-1:0]   rom_addr,
  output logic [7:0]             rom_data,
  output logic                   core_reset_n,
  output logic                   dl_busy,
  output logic                   dl_error,
  output logic [BYTE_CNT_W-1:0]  byte_count
);

  localparam int IDXW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int HCW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_CYCLES - 1);
  localparam logic [24:0] ADDR_LIMIT = 25'(EXPECTED_BYTES);
  localparam logic [BYTE_CNT_W-1:0] CNT_GOOD = BYTE_CNT_W'(EXPECTED_BYTES);

  dl_state_t state, state_nxt;

  logic [HCW-1:0]         hold_cnt, hold_cnt_nxt;
  logic [NUM_REGIONS-1:0] rom_wr_nxt;
  logic [BYTE_CNT_W-1:0]  cnt_base, cnt_nxt;
  logic                   err_nxt;
  logic                   entering;
  logic                   wr_take;
  logic                   in_range;
  logic [IDXW-1:0]        rgn_idx;

  assign in_range = ioctl_addr < ADDR_LIMIT;
  assign rgn_idx  = ioctl_addr[REGION_AW +: IDXW];

  // State register.
  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) state <= HOLD;
    else          state <= state_nxt;
  end

  // Next-state: download always wins over ext_reset.
  always_comb begin
    state_nxt = state;
    unique case (state)
      HOLD: begin
        if (ioctl_download)     state_nxt = LOAD;
        else if (hold_cnt == 0) state_nxt = RUN;
      end
      RUN: begin
        if (ioctl_download) state_nxt = LOAD;
        else if (ext_reset) state_nxt = HOLD;
      end
      LOAD: begin
        if (!ioctl_download) state_nxt = CHECK;
      end
      CHECK: begin
        if (byte_count == CNT_GOOD && !dl_error) state_nxt = HOLD;
        else                                     state_nxt = FAULT;
      end
      FAULT: begin
        if (ioctl_download) state_nxt = LOAD;
      end
      default: state_nxt = HOLD;
    endcase
  end

  // Datapath next values: strobe, counters, sticky error.
  always_comb begin
    entering = (state != LOAD) && (state_nxt == LOAD);
    // Last byte may arrive as download falls, so LOAD accepts it.
    wr_take  = ioctl_wr &&
               ((state == LOAD) || (ioctl_download && entering));

    hold_cnt_nxt = hold_cnt;
    if (state != HOLD && state_nxt == HOLD) hold_cnt_nxt = HOLD_INIT;
    else if (state == HOLD && hold_cnt != 0) hold_cnt_nxt = hold_cnt - 1'b1;

    rom_wr_nxt = '0;
    if (wr_take && in_range) rom_wr_nxt[rgn_idx] = 1'b1;

    cnt_base = entering ? '0 : byte_count;
    cnt_nxt  = cnt_base;
    if (wr_take && in_range && cnt_base != BYTE_CNT_MAX)
      cnt_nxt = cnt_base + 1'b1;

    err_nxt = entering ? 1'b0 : dl_error;
    if (wr_take && !in_range) err_nxt = 1'b1;
    if (state == CHECK && state_nxt == FAULT) err_nxt = 1'b1;
  end

  // Registered outputs and counters.
  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) begin
      hold_cnt     <= HOLD_INIT;
      rom_wr       <= '0;
      rom_addr     <= '0;
      rom_data     <= '0;
      core_reset_n <= 1'b0;
      dl_busy      <= 1'b0;
      dl_error     <= 1'b0;
      byte_count   <= '0;
    end else begin
      hold_cnt     <= hold_cnt_nxt;
      rom_wr       <= rom_wr_nxt;
      if (wr_take && in_range) begin
        rom_addr <= ioctl_addr[REGION_AW-1:0];
        rom_data <= ioctl_data;
      end
      core_reset_n <= (state_nxt == RUN);
      dl_busy      <= (state_nxt == LOAD) || (state_nxt == CHECK);
      dl_error     <= err_nxt;
      byte_count   <= cnt_nxt;
    end
  end

endmodule
